// File: rtl/tf_spi_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : tf_spi_engine_if
// Description : Byte-request handshake between the TF card register
//               controller (master) and the SPI byte engine (slave).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   req        controller -> engine  start a byte transfer (sampled in IDLE)
//   tx_data    controller -> engine  byte to send, latched on accept
//   fast       controller -> engine  1 = fast half-period, 0 = slow
//   cs_assert  controller -> engine  1 = card selected (applied between bytes)
//   auto_rd    controller -> engine  read-ahead enable
//   rd_ack     controller -> engine  pulse: rx_data consumed
//   busy       engine -> controller  transfer in progress
//   done       engine -> controller  one-cycle pulse, rx_data valid
//   rx_data    engine -> controller  last received byte
// ============================================================================
interface tf_spi_engine_if;
  logic       req;
  logic [7:0] tx_data;
  logic       fast;
  logic       cs_assert;
  logic       auto_rd;
  logic       rd_ack;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;

  modport master (
    output req, tx_data, fast, cs_assert, auto_rd, rd_ack,
    input  busy, done, rx_data
  );

  modport slave (
    input  req, tx_data, fast, cs_assert, auto_rd, rd_ack,
    output busy, done, rx_data
  );
endinterface
`default_nettype wire

// File: rtl/tf_spi_engine.sv
`default_nettype none
// ============================================================================
// Module      : tf_spi_engine
// Description : Byte-level SPI master (mode 0, MSB first) driving the TF card
//               pins. One byte per request at a slow (card-init) or fast
//               SCLK rate; the received byte is returned with a one-cycle
//               done pulse. Chip-select only changes between bytes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   HALF_SLOW  CLK cycles per SCLK half-period in slow mode (1..255)
//   HALF_FAST  CLK cycles per SCLK half-period in fast mode (1..255)
// Ports:
//   CLK        system clock, rising edge
//   RESET_n    asynchronous active-low reset
//   bus        tf_spi_engine_if.slave request/response handshake
//   SCLK, MOSI, CS_n  TF card output pins
//   MISO       TF card input pin
// Build option:
//   TF_SPI_READAHEAD_EN  when defined, rd_ack with auto_rd (and no req) in
//                        IDLE starts an 8'hFF transfer at the current fast
//                        value. When undefined auto_rd/rd_ack are ignored.
// ============================================================================
module tf_spi_engine #(
  parameter int HALF_SLOW = 34,
  parameter int HALF_FAST = 1
) (
  input  logic           CLK,
  input  logic           RESET_n,
  tf_spi_engine_if.slave bus,
  output logic           SCLK,
  output logic           MOSI,
  output logic           CS_n,
  input  logic           MISO
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;

  localparam logic [7:0] C_SLOW_M1 = 8'(HALF_SLOW - 1);
  localparam logic [7:0] C_FAST_M1 = 8'(HALF_FAST - 1);

  logic [1:0] state_q,   state_d;
  logic [7:0] div_q,     div_d;
  logic [2:0] bit_q,     bit_d;
  logic [7:0] tx_sh_q,   tx_sh_d;
  logic [7:0] rx_sh_q,   rx_sh_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       fast_q,    fast_d;
  logic       sclk_q,    sclk_d;
  logic       mosi_q,    mosi_d;
  logic       cs_n_q,    cs_n_d;
  logic       busy_q,    busy_d;
  logic       done_q,    done_d;
  logic       miso_q,    miso_d;

  logic       w_start;
  logic [7:0] w_start_byte;
  logic [7:0] w_half_m1;
  logic [7:0] w_start_half_m1;
  logic [7:0] w_rx_next;

`ifdef TF_SPI_READAHEAD_EN
  // An explicit req always wins over a read-ahead and supplies its own byte.
  assign w_start      = bus.req | (bus.auto_rd & bus.rd_ack);
  assign w_start_byte = bus.req ? bus.tx_data : 8'hFF;
`else
  logic unused_readahead;
  assign unused_readahead = bus.auto_rd ^ bus.rd_ack;
  assign w_start          = bus.req;
  assign w_start_byte     = bus.tx_data;
`endif

  // Reload value for the transfer in flight, and for the one being started
  // (which must use the live fast input, not the stale latched copy).
  assign w_half_m1       = fast_q   ? C_FAST_M1 : C_SLOW_M1;
  assign w_start_half_m1 = bus.fast ? C_FAST_M1 : C_SLOW_M1;
  assign w_rx_next       = {rx_sh_q[6:0], miso_q};

  assign miso_d = MISO;

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    fast_d    = fast_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // CS tracks the request only while idle, so it never glitches mid-byte.
        cs_n_d = ~bus.cs_assert;
        if (w_start) begin
          state_d = ST_LOW;
          tx_sh_d = w_start_byte;
          mosi_d  = w_start_byte[7];
          fast_d  = bus.fast;
          bit_d   = 3'd7;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          div_d   = w_start_half_m1;
        end
      end

      ST_LOW: begin
        if (div_q == 8'd0) begin
          state_d = ST_HIGH;
          sclk_d  = 1'b1;
          div_d   = w_half_m1;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      ST_HIGH: begin
        if (div_q == 8'd0) begin
          // Sample on the last CLK of the high phase using the registered MISO.
          rx_sh_d = w_rx_next;
          sclk_d  = 1'b0;
          if (bit_q == 3'd0) begin
            state_d   = ST_IDLE;
            mosi_d    = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            rx_data_d = w_rx_next;
          end else begin
            state_d = ST_LOW;
            bit_d   = bit_q - 3'd1;
            tx_sh_d = {tx_sh_q[6:0], 1'b1};
            mosi_d  = tx_sh_q[6];
            div_d   = w_half_m1;
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q   <= ST_IDLE;
      div_q     <= 8'd0;
      bit_q     <= 3'd0;
      tx_sh_q   <= 8'hFF;
      rx_sh_q   <= 8'hFF;
      rx_data_q <= 8'hFF;
      fast_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b1;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      miso_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      fast_q    <= fast_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      miso_q    <= miso_d;
    end
  end

  assign SCLK        = sclk_q;
  assign MOSI        = mosi_q;
  assign CS_n        = cs_n_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_tf_spi_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_tf_spi_engine
// Description : Directed self-checking bench for tf_spi_engine
//               (HALF_SLOW=34, HALF_FAST=1). Honours TF_SPI_READAHEAD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tf_spi_engine;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk, mosi, cs_n, miso;

  tf_spi_engine_if bus ();

  tf_spi_engine #(
    .HALF_SLOW (34),
    .HALF_FAST (1)
  ) dut (
    .CLK     (clk),
    .RESET_n (rst_n),
    .bus     (bus),
    .SCLK    (sclk),
    .MOSI    (mosi),
    .CS_n    (cs_n),
    .MISO    (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pin/handshake monitor, sampled mid-cycle.
  int         done_cnt  = 0;
  int         rise_cnt  = 0;
  int         fall_cnt  = 0;
  int         rise_cyc  = 0;
  int         rise_gap  = 0;
  int         high_len  = 0;
  logic [7:0] mosi_cap  = 8'h00;
  logic       sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (sclk === 1'b1 && sclk_prev == 1'b0) begin
      rise_cnt++;
      mosi_cap = {mosi_cap[6:0], mosi};
      rise_gap = cyc - rise_cyc;
      rise_cyc = cyc;
    end
    if (sclk === 1'b0 && sclk_prev == 1'b1) begin
      fall_cnt++;
      high_len = cyc - rise_cyc;
    end
    sclk_prev = (sclk === 1'b1);
  end

  // Card model: either MOSI loopback, or a byte shifted out MSB first with
  // the next bit presented after each falling SCLK.
  logic       loop_mode = 1'b1;
  logic [7:0] resp      = 8'hFF;
  int         fall_base = 0;
  logic       model_bit;
  always @* begin
    if ((fall_cnt - fall_base) < 8 && (fall_cnt - fall_base) >= 0)
      model_bit = resp[3'(7 - (fall_cnt - fall_base))];
    else
      model_bit = 1'b1;
  end
  assign miso = loop_mode ? mosi : model_bit;

  int n_tests = 0;
  int n_fail  = 0;
  int t0, done_at, base_done, rise_base;
  bit found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge of cycle 1.
  task automatic start_xfer(input logic [7:0] data, input logic f);
    bus.tx_data = data;
    bus.fast    = f;
    bus.req     = 1'b1;
    t0          = cyc;
    @(negedge clk);
    bus.req     = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string tag);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        found   = 1'b1;
        done_at = cyc;
      end
    end
    check({tag, "_done_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req       = 1'b0;
    bus.tx_data   = 8'h00;
    bus.fast      = 1'b0;
    bus.cs_assert = 1'b0;
    bus.auto_rd   = 1'b0;
    bus.rd_ack    = 1'b0;

    // Reset while idle.
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd1);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rx",   32'(bus.rx_data), 32'hFF);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in cycle 5 of a slow transfer.
    base_done = done_cnt;
    start_xfer(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_mosi", 32'(mosi), 32'd1);
    check("midrst_rx",   32'(bus.rx_data), 32'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - base_done), 32'd0);

    // Slow byte, loopback.
    loop_mode = 1'b1;
    rise_base = rise_cnt;
    start_xfer(8'hA5, 1'b0);
    wait_done(700, "slow");
    check("slow_latency", 32'(done_at - t0), 32'd545);
    check("slow_rx", 32'(bus.rx_data), 32'hA5);
    check("slow_busy_at_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("slow_pulses", 32'(rise_cnt - rise_base), 32'd8);
    check("slow_last_rise", 32'(rise_cyc - t0), 32'd511);
    check("slow_rise_gap", 32'(rise_gap), 32'd68);
    check("slow_high_len", 32'(high_len), 32'd34);
    check("slow_mosi_idle", 32'(mosi), 32'd1);
    check("slow_done_one_cycle", 32'(bus.done), 32'd0);

    // Fast byte against a card returning 8'hC3.
    loop_mode = 1'b0;
    resp      = 8'hC3;
    fall_base = fall_cnt;
    rise_base = rise_cnt;
    start_xfer(8'h3C, 1'b1);
    wait_done(40, "fast");
    check("fast_latency", 32'(done_at - t0), 32'd17);
    check("fast_rx", 32'(bus.rx_data), 32'hC3);
    @(negedge clk);
    check("fast_pulses", 32'(rise_cnt - rise_base), 32'd8);
    check("fast_mosi_at_rise", 32'(mosi_cap), 32'h3C);
    loop_mode = 1'b1;

    // Second req mid-transfer is ignored.
    base_done = done_cnt;
    start_xfer(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    bus.tx_data = 8'h0F;
    bus.req     = 1'b1;
    @(negedge clk);
    bus.req     = 1'b0;
    wait_done(40, "ign");
    check("ign_latency", 32'(done_at - t0), 32'd17);
    check("ign_rx", 32'(bus.rx_data), 32'h55);
    repeat (40) @(negedge clk);
    check("ign_single_done", 32'(done_cnt - base_done), 32'd1);

    // req held high: back-to-back bytes every 17 cycles.
    bus.tx_data = 8'h81;
    bus.fast    = 1'b1;
    bus.req     = 1'b1;
    t0          = cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_done(40, "b2b");
      check("b2b_period", 32'(done_at - t0), 32'(17 * k));
      check("b2b_rx", 32'(bus.rx_data), 32'h81);
    end
    bus.req = 1'b0;
    @(negedge clk);
    check("b2b_stopped", 32'(bus.busy), 32'd0);

    // cs_assert change mid-transfer is deferred until after done.
    start_xfer(8'hA5, 1'b0);
    repeat (2) @(negedge clk);
    bus.cs_assert = 1'b1;
    repeat (97) @(negedge clk);
    check("cs_hold_mid", 32'(cs_n), 32'd1);
    wait_done(700, "cs");
    check("cs_latency", 32'(done_at - t0), 32'd545);
    check("cs_at_done", 32'(cs_n), 32'd1);
    @(negedge clk);
    check("cs_after_done", 32'(cs_n), 32'd0);

    // Read-ahead on rd_ack.
    bus.auto_rd = 1'b1;
    start_xfer(8'h12, 1'b1);
    wait_done(40, "ra_first");
    check("ra_first_rx", 32'(bus.rx_data), 32'h12);
    @(negedge clk);
    rise_base  = rise_cnt;
    base_done  = done_cnt;
    bus.rd_ack = 1'b1;
    t0         = cyc;
    @(negedge clk);
    bus.rd_ack = 1'b0;
`ifdef TF_SPI_READAHEAD_EN
    wait_done(40, "ra");
    check("ra_latency", 32'(done_at - t0), 32'd17);
    check("ra_rx", 32'(bus.rx_data), 32'hFF);
    @(negedge clk);
    check("ra_mosi_bits", 32'(mosi_cap), 32'hFF);
    check("ra_pulses", 32'(rise_cnt - rise_base), 32'd8);
`else
    repeat (40) @(negedge clk);
    check("ra_off_no_done", 32'(done_cnt - base_done), 32'd0);
    check("ra_off_no_sclk", 32'(rise_cnt - rise_base), 32'd0);
    check("ra_off_rx", 32'(bus.rx_data), 32'h12);
`endif
    bus.auto_rd = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tf_spi_engine.md
# tf_spi_engine

Byte-level SPI master that sits directly downstream of the TF card register controller and drives the TF card pins. It accepts one byte per request, shifts it out in SPI mode 0 at a selectable slow (card-init) or fast rate, and returns the received byte with a one-cycle completion pulse. Chip-select is controlled by the upstream controller and is applied only between bytes.

## Interface
- HALF_SLOW, 34: CLK cycles per SCLK half-period in slow mode. At 27 MHz this gives ≈397 kHz. Range 1..255.
- HALF_FAST, 1: CLK cycles per SCLK half-period in fast mode. Range 1..255.
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET_n  in  1  asynchronous active-low reset.
- req  in  1  start a byte transfer. Sampled only in IDLE.
- tx_data  in  8  byte to send. Latched when req is accepted.
- fast  in  1  1 = HALF_FAST, 0 = HALF_SLOW. Latched when req is accepted.
- cs_assert  in  1  1 = TF card selected.
- auto_rd  in  1  enables read-ahead. Used only with TF_SPI_READAHEAD_EN.
- rd_ack  in  1  one-cycle pulse: upstream has consumed rx_data. Used only with TF_SPI_READAHEAD_EN.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse; rx_data is valid.
- rx_data  out  8  last received byte. Held until the next done.
- SCLK, MOSI, CS_n  out  1 each  TF pins.
- MISO  in  1  TF pin.

## Operation
- Reset values: SCLK=0, MOSI=1, CS_n=1, busy=0, done=0, rx_data=8'hFF, state IDLE, divider counter=0.
- States:
  - IDLE → LOW when a start occurs.
  - LOW → HIGH when the divider expires.
  - HIGH → LOW when the divider expires and bits remain.
  - HIGH → IDLE after bit 0.
- Start (IDLE only, req=1):
  - latch tx_data into the shift register and latch fast into the half-period select;
  - set bit counter to 7, busy=1, MOSI=tx_data[7], SCLK=0.
- SPI mode 0 (CPOL=0, CPHA=0), MSB first.
- LOW phase: SCLK=0. MOSI holds the current bit.
- HIGH phase: SCLK=1.
  - On the last CLK of HIGH, shift the registered MISO value into the receive shift register LSB.
  - Then decrement the bit counter and present the next bit on MOSI.
- MISO passes through exactly one input flop before sampling.
- End of bit 0 HIGH:
  - SCLK=0, MOSI=1, busy=0;
  - rx_data ← receive shift register;
  - done=1 for exactly one cycle.
- Divider: an 8-bit counter reloads to half-1 on every phase entry and expires at 0.
- req while busy is ignored. Upstream must wait for done. req held high through done starts a new transfer on the cycle after done (IDLE).
- Chip-select:
  - CS_n ← ~cs_assert, registered, updated only while in IDLE;
  - a change during a transfer takes effect on the cycle after done;
  - a start and a CS change in the same IDLE cycle are both applied; CS_n changes in the same cycle SCLK phase LOW begins.
- A change of fast during a transfer has no effect on that transfer.
- Reset asserted mid-transfer immediately forces all reset values. No done is issued. The partial byte is discarded.

## Timing
- Req accepted in cycle 0 → busy=1 from cycle 1.
- With H = latched half-period:
  - rising SCLK edges at cycles 1+H, 1+3H, …, 1+15H;
  - done=1 and busy=0 at cycle 1+16H.
- Slow default: done at cycle 545. Fast default: done at cycle 17.
- Back-to-back throughput: one byte per 16H+1 cycles.
- done and busy=0 are coincident. rx_data changes only in the done cycle.

## Configuration
- TF_SPI_READAHEAD_EN defined:
  - in IDLE, rd_ack=1 with auto_rd=1 and req=0 starts a transfer of 8'hFF at the current fast value, with identical timing to req;
  - req=1 in the same cycle takes priority and uses tx_data;
  - rd_ack while busy is ignored.
- TF_SPI_READAHEAD_EN undefined: auto_rd and rd_ack are ignored. Ports remain present.

## Test plan
- Reset during idle and again mid-transfer at cycle 5 → all outputs at their reset values; no done; next req behaves normally.
- fast=0, tx_data=8'hA5, MISO looped from MOSI → SCLK has 8 pulses with 34-cycle halves; done at cycle 545; rx_data=8'hA5; MOSI=1 afterwards.
- fast=1, tx_data=8'h3C, MISO driven by a model returning 8'hC3 → done at cycle 17; rx_data=8'hC3; MOSI bits valid at every rising SCLK.
- Second req pulsed at cycle 5 of a fast transfer → ignored; exactly one done.
- Hold req=1 continuously → back-to-back done pulses every 17 cycles.
- cs_assert 0→1 at cycle 3 of a slow transfer → CS_n stays 1 until cycle 546, then 0.
- TF_SPI_READAHEAD_EN defined, auto_rd=1, rd_ack pulsed one cycle after done → new transfer sends 8'hFF; done 16H+1 cycles after the rd_ack. With the macro undefined, the same stimulus → no transfer.
